// File: rtl/sipo_packer_pkg.sv
// Shared types and helpers for the serial-in/parallel-out packer.
// Fill order selects which end of the word beat 0 lands in.
package sipo_packer_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } fill_order_e;

  function automatic int beat_count(input int word_width, input int lanes);
    return word_width / lanes;
  endfunction

endpackage

// File: rtl/sipo_fifo.sv
// Synchronous WIDTH x DEPTH word FIFO, registered storage, no push-to-pop bypass.
// Pushes into a full FIFO are dropped unless a pop frees the slot on the same edge.
module sipo_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push_vld,
  input  logic [WIDTH-1:0]             i_push_dat,
  output logic                         o_pop_vld,
  input  logic                         i_pop_rdy,
  output logic [WIDTH-1:0]             o_pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_overflow
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  always_comb begin
    w_empty = (r_level == '0);
    w_full  = (r_level == LW'(DEPTH));
    w_pop   = ~w_empty & i_pop_rdy;
    w_push  = i_push_vld & (~w_full | w_pop);
    w_drop  = i_push_vld & w_full & ~w_pop;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: the pointers and level define what is live.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_comb begin
    o_pop_vld  = ~w_empty & ~i_rst;
    o_pop_dat  = o_pop_vld ? r_mem[r_rd_ptr] : '0;
    o_level    = i_rst ? '0 : r_level;
    o_overflow = r_overflow & ~i_rst;
  end

endmodule

// File: rtl/sipo_packer.sv
// Packs LANES-bit serial beats into WORD_WIDTH words; word is valid the cycle after its last beat.
// Output side is valid/ready through a DEPTH-word FIFO; words completing into a full FIFO are dropped.
module sipo_packer #(
  parameter int WORD_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int DEPTH      = 2,
  parameter int MSB_FIRST  = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clk_en_i,
  input  logic [LANES-1:0]             serial_i,
  input  logic                         serial_valid_i,
  input  logic                         frame_i,
  output logic [WORD_WIDTH-1:0]        parallel_o,
  output logic                         parallel_valid_o,
  input  logic                         parallel_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         overflow_o,
  output logic                         frame_err_o
);

  import sipo_packer_pkg::*;

  localparam int          N    = beat_count(WORD_WIDTH, LANES);
  localparam int          KW   = (N > 1) ? $clog2(N) : 1;
  localparam fill_order_e FILL = (MSB_FIRST != 0) ? sipo_packer_pkg::MSB_FIRST : LSB_FIRST;

  if ((WORD_WIDTH % LANES) != 0 || DEPTH < 1) begin : g_bad_params
    $error("sipo_packer: WORD_WIDTH must be a multiple of LANES and DEPTH must be >= 1");
  end

  logic [KW-1:0]         r_k;
  logic [WORD_WIDTH-1:0] r_shift;
  logic                  r_frame_err;

  logic                  w_accept;
  logic [KW-1:0]         w_k_eff;
  logic [WORD_WIDTH-1:0] w_word;
  logic                  w_last;

  // A framed beat restarts at index 0 and starts from a clean word.
  always_comb begin
    w_accept = clk_en_i & serial_valid_i;
    w_k_eff  = frame_i ? '0 : r_k;
    w_word   = (frame_i || r_k == '0) ? '0 : r_shift;
    if (FILL == LSB_FIRST) begin
      w_word[int'(w_k_eff)*LANES +: LANES] = serial_i;
    end else begin
      w_word[WORD_WIDTH-1-int'(w_k_eff)*LANES -: LANES] = serial_i;
    end
    w_last = w_accept && (int'(w_k_eff) == N - 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_k         <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_accept & frame_i & (r_k != '0);
      if (w_accept) begin
        if (w_last) begin
          r_k     <= '0;
          r_shift <= '0;
        end else begin
          r_k     <= w_k_eff + KW'(1);
          r_shift <= w_word;
        end
      end
    end
  end

  sipo_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_push_vld (w_last),
    .i_push_dat (w_word),
    .o_pop_vld  (parallel_valid_o),
    .i_pop_rdy  (parallel_ready_i),
    .o_pop_dat  (parallel_o),
    .o_level    (level_o),
    .o_overflow (overflow_o)
  );

  assign frame_err_o = r_frame_err & ~rst_i;

endmodule

// File: tb/tb_sipo_packer.sv
// Directed bench for sipo_packer: an LSB-first 1-lane instance and an MSB-first 2-lane instance,
// with expected words queued at stimulus time and popped by a negedge monitor.
module tb_sipo_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en1, vld1, fr1, s1, rdy1;
  logic [7:0] p1;
  logic       pv1, ovf1, ferr1;
  logic [1:0] lvl1;

  logic       en2, vld2, fr2, rdy2;
  logic [1:0] s2;
  logic [7:0] p2;
  logic       pv2, ovf2, ferr2;
  logic [1:0] lvl2;

  sipo_packer #(.WORD_WIDTH(8), .LANES(1), .DEPTH(2), .MSB_FIRST(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .clk_en_i(en1), .serial_i(s1), .serial_valid_i(vld1),
    .frame_i(fr1), .parallel_o(p1), .parallel_valid_o(pv1), .parallel_ready_i(rdy1),
    .level_o(lvl1), .overflow_o(ovf1), .frame_err_o(ferr1));

  sipo_packer #(.WORD_WIDTH(8), .LANES(2), .DEPTH(2), .MSB_FIRST(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .clk_en_i(en2), .serial_i(s2), .serial_valid_i(vld2),
    .frame_i(fr2), .parallel_o(p2), .parallel_valid_o(pv2), .parallel_ready_i(rdy2),
    .level_o(lvl2), .overflow_o(ovf2), .frame_err_o(ferr2));

  int         n_chk = 0;
  int         n_fail = 0;
  int         ovf_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (pv1 && rdy1) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL dut1_unexpected_word: got 0x%0h, expected no word", p1);
      end else begin
        e = q1.pop_front();
        chk("dut1_word", 32'(p1), 32'(e));
      end
    end
    if (pv2 && rdy2) begin
      if (q2.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL dut2_unexpected_word: got 0x%0h, expected no word", p2);
      end else begin
        e = q2.pop_front();
        chk("dut2_word", 32'(p2), 32'(e));
      end
    end
    if (ovf1)  ovf_cnt++;
    if (ferr1) ferr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat1(input logic b, input logic fr, input logic en);
    s1 = b; fr1 = fr; en1 = en; vld1 = 1'b1;
    tick();
    vld1 = 1'b0; fr1 = 1'b0; en1 = 1'b1;
  endtask

  task automatic send1(input logic [7:0] w);
    for (int i = 0; i < 8; i++) beat1(w[i], 1'b0, 1'b1);
  endtask

  task automatic drain1(input string nm);
    int t = 0;
    while (q1.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    chk(nm, q1.size(), 0);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       s1_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] s2_beats [4] = '{2'b11, 2'b00, 2'b10, 2'b01};
    logic [7:0] w;
    int         t;

    rst = 1'b1; en1 = 1'b1; vld1 = 1'b0; fr1 = 1'b0; s1 = 1'b0; rdy1 = 1'b1;
    en2 = 1'b1; vld2 = 1'b0; fr2 = 1'b0; s2 = 2'b00; rdy2 = 1'b1;
    repeat (2) tick();
    chk("rst_valid", 32'(pv1), 0);
    chk("rst_level", 32'(lvl1), 0);
    chk("rst_data", 32'(p1), 0);
    chk("rst_flags", 32'({ovf1, ferr1, pv2}), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 32'(pv1), 0);
    chk("post_rst_level", 32'(lvl2), 0);

    // Scenario 1: LSB-first, one lane
    for (int i = 0; i < 7; i++) beat1(s1_bits[i], 1'b0, 1'b1);
    chk("s1_not_early", 32'(pv1), 0);
    q1.push_back(8'hC5);
    beat1(s1_bits[7], 1'b0, 1'b1);
    chk("s1_latency_valid", 32'(pv1), 1);
    chk("s1_word_c5", 32'(p1), 32'h0000_00C5);
    chk("s1_level", 32'(lvl1), 1);
    tick();
    chk("s1_popped_level", 32'(lvl1), 0);

    // Scenario 2: MSB-first, two lanes
    q2.push_back(8'hC9);
    for (int i = 0; i < 4; i++) begin
      s2 = s2_beats[i]; vld2 = 1'b1;
      tick();
    end
    vld2 = 1'b0;
    chk("s2_valid", 32'(pv2), 1);
    chk("s2_word_c9", 32'(p2), 32'h0000_00C9);
    tick();

    // Scenario 3: fill, overflow, then push+pop while full
    rdy1 = 1'b0;
    q1.push_back(8'h3C); send1(8'h3C);
    q1.push_back(8'hA5); send1(8'hA5);
    chk("s3_level_full", 32'(lvl1), 2);
    chk("s3_head", 32'(p1), 32'h3C);
    send1(8'h0F);
    chk("s3_overflow_pulse", 32'(ovf1), 1);
    chk("s3_level_kept", 32'(lvl1), 2);
    tick();
    chk("s3_overflow_one_cycle", 32'(ovf1), 0);
    chk("s3_head_stable", 32'(p1), 32'h3C);
    w = 8'h96;
    q1.push_back(w);
    for (int i = 0; i < 7; i++) beat1(w[i], 1'b0, 1'b1);
    rdy1 = 1'b1;
    beat1(w[7], 1'b0, 1'b1);
    chk("s3_full_pushpop_no_ovf", 32'(ovf1), 0);
    chk("s3_full_pushpop_level", 32'(lvl1), 2);
    drain1("s3_drain");
    chk("s3_ovf_count", ovf_cnt, 1);

    // Scenario 4: frame after 3 beats discards the partial word
    beat1(1'b1, 1'b1, 1'b1);
    beat1(1'b0, 1'b0, 1'b1);
    beat1(1'b1, 1'b0, 1'b1);
    chk("s4_no_early_ferr", 32'(ferr1), 0);
    w = 8'h5A;
    q1.push_back(w);
    beat1(w[0], 1'b1, 1'b1);
    chk("s4_ferr_pulse", 32'(ferr1), 1);
    beat1(w[1], 1'b0, 1'b1);
    chk("s4_ferr_one_cycle", 32'(ferr1), 0);
    for (int i = 2; i < 8; i++) beat1(w[i], 1'b0, 1'b1);
    drain1("s4_drain");
    chk("s4_ferr_count", ferr_cnt, 1);

    // Scenario 5: enable toggling; disabled beats carry garbage and frame
    w = 8'hE1;
    q1.push_back(w);
    for (int i = 0; i < 8; i++) begin
      beat1(~w[i], 1'b1, 1'b0);
      beat1(w[i], 1'b0, 1'b1);
    end
    chk("s5_valid", 32'(pv1), 1);
    beat1(1'b1, 1'b1, 1'b0);
    beat1(1'b0, 1'b1, 1'b0);
    chk("s5_drain_en0_level", 32'(lvl1), 0);
    chk("s5_drain_en0_queue", q1.size(), 0);
    chk("s5_ferr_count", ferr_cnt, 1);

    // Scenario 6: reset mid-word with one word stored
    rdy1 = 1'b0;
    send1(8'h11);
    chk("s6_stored", 32'(lvl1), 1);
    for (int i = 0; i < 5; i++) beat1(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("s6_valid_cleared", 32'(pv1), 0);
    chk("s6_level_cleared", 32'(lvl1), 0);
    chk("s6_no_flags", 32'({ovf1, ferr1}), 0);
    rdy1 = 1'b1;
    q1.push_back(8'h6B);
    send1(8'h6B);
    chk("s6_clean_word", 32'(p1), 32'h6B);
    drain1("s6_drain");
    chk("final_ovf_count", ovf_cnt, 1);
    chk("final_ferr_count", ferr_cnt, 1);

    t = 0;
    while (q2.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    chk("dut2_queue_empty", q2.size(), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
